mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the CPU instruction bus (Iw*) and data bus (Dw*).

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU instruction and data buses.
// Data wins by default; instruction fetch is forced after MAX_D_STREAK data grants in a row.
module mem_port_arbiter #(
   parameter int unsigned MAX_D_STREAK = 4,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iIReq,
   input  logic        iIWe,
   input  logic [3:0]  iIBe,
   input  logic [31:0] iIAddr,
   input  logic [31:0] iIWData,
   output logic [31:0] oIRData,
   output logic        oIAck,
   input  logic        iDReq,
   input  logic        iDWe,
   input  logic [3:0]  iDBe,
   input  logic [31:0] iDAddr,
   input  logic [31:0] iDWData,
   output logic [31:0] oDRData,
   output logic        oDAck,
   output logic        oMemRe,
   output logic        oMemWe,
   output logic [3:0]  oMemBe,
   output logic [31:0] oMemAddr,
   output logic [31:0] oMemWData,
   input  logic [31:0] iMemRData,
   input  logic        iMemReady,
   output logic        oTimeout,
   output logic [1:0]  oDbgState
);

   // Handshake: a requester raises iXReq with its fields and holds them until oXAck;
   // the arbiter asserts oMemRe/oMemWe until iMemReady=1 or the watchdog expires.

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_D_STREAK);
   localparam logic [7:0] LP_TIMEOUT    = 8'(TIMEOUT);

   state_t      r_state;
   logic [3:0]  r_streak;
   logic [7:0]  r_wdog;

   logic        w_force_i;
   logic        w_grant_d;
   logic        w_finish;
   logic [31:0] w_rdata;

   assign w_force_i = iIReq && (r_streak == LP_MAX_STREAK);
   assign w_grant_d = iDReq && !w_force_i;
   // r_wdog counts BUSY cycles including the current one, so it reaches TIMEOUT on the last allowed cycle.
   assign w_finish  = iMemReady || (r_wdog == LP_TIMEOUT);
   assign w_rdata   = (iMemReady && !oMemWe) ? iMemRData : 32'd0;
   assign oDbgState = r_state;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         r_state   <= ST_IDLE;
         r_streak  <= 4'd0;
         r_wdog    <= 8'd0;
         oIRData   <= 32'd0;
         oIAck     <= 1'b0;
         oDRData   <= 32'd0;
         oDAck     <= 1'b0;
         oMemRe    <= 1'b0;
         oMemWe    <= 1'b0;
         oMemBe    <= 4'd0;
         oMemAddr  <= 32'd0;
         oMemWData <= 32'd0;
         oTimeout  <= 1'b0;
      end else begin
         oIAck <= 1'b0;
         oDAck <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_d) begin
                  r_state   <= ST_BUSY_D;
                  oMemRe    <= !iDWe;
                  oMemWe    <= iDWe;
                  oMemBe    <= iDBe;
                  oMemAddr  <= iDAddr;
                  oMemWData <= iDWData;
                  r_streak  <= iIReq ? (r_streak + 4'd1) : 4'd0;
                  r_wdog    <= 8'd1;
               end else if (iIReq) begin
                  r_state   <= ST_BUSY_I;
                  oMemRe    <= !iIWe;
                  oMemWe    <= iIWe;
                  oMemBe    <= iIBe;
                  oMemAddr  <= iIAddr;
                  oMemWData <= iIWData;
                  r_streak  <= 4'd0;
                  r_wdog    <= 8'd1;
               end
            end
            ST_BUSY_I, ST_BUSY_D: begin
               if (w_finish) begin
                  r_state <= ST_DONE;
                  oMemRe  <= 1'b0;
                  oMemWe  <= 1'b0;
                  if (r_state == ST_BUSY_I) begin
                     oIAck   <= 1'b1;
                     oIRData <= w_rdata;
                  end else begin
                     oDAck   <= 1'b1;
                     oDRData <= w_rdata;
                  end
                  if (!iMemReady) begin
                     oTimeout <= 1'b1;
                  end
               end else begin
                  r_wdog <= r_wdog + 8'd1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random two-port traffic,
// checked by a transaction-level reference model feeding expectation queues.
module tb_mem_port_arbiter;

   localparam int MAX_D  = 4;
   localparam int TMO    = 8;
   localparam int NEVER  = 1000;

   logic        iCLK, iRST;
   logic        iIReq, iIWe, iDReq, iDWe;
   logic [3:0]  iIBe, iDBe;
   logic [31:0] iIAddr, iIWData, iDAddr, iDWData;
   logic [31:0] oIRData, oDRData;
   logic        oIAck, oDAck;
   logic        oMemRe, oMemWe;
   logic [3:0]  oMemBe;
   logic [31:0] oMemAddr, oMemWData;
   logic [31:0] iMemRData;
   logic        iMemReady;
   logic        oTimeout;
   logic [1:0]  oDbgState;

   mem_port_arbiter #(.MAX_D_STREAK(MAX_D), .TIMEOUT(TMO)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iIReq(iIReq), .iIWe(iIWe), .iIBe(iIBe), .iIAddr(iIAddr), .iIWData(iIWData),
      .oIRData(oIRData), .oIAck(oIAck),
      .iDReq(iDReq), .iDWe(iDWe), .iDBe(iDBe), .iDAddr(iDAddr), .iDWData(iDWData),
      .oDRData(oDRData), .oDAck(oDAck),
      .oMemRe(oMemRe), .oMemWe(oMemWe), .oMemBe(oMemBe), .oMemAddr(oMemAddr),
      .oMemWData(oMemWData), .iMemRData(iMemRData), .iMemReady(iMemReady),
      .oTimeout(oTimeout), .oDbgState(oDbgState)
   );

   // ---------------- clock ----------------
   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_bad = 0;
   bit done_flag = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   // ---------------- memory contents ----------------
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_3C3C;
   endfunction

   // ---------------- reference model (transaction level) ----------------
   logic [32:0] exp_q[$];     // {port_is_d, rdata}
   logic [68:0] grant_q[$];   // {we, be, addr, wdata}
   int  cyc = 0;
   int  m_next = 0;           // first cycle at which a new grant may happen
   bit  m_act = 0;
   int  m_start = 0;
   bit  m_port_d = 0;
   bit  m_we = 0;
   logic [31:0] m_rd = '0;
   int  m_d_run = 0;          // D grants in a row while I was waiting
   bit  m_to = 0;

   always @(posedge iCLK) begin
      if (iRST) begin
         cyc++;
         if (m_act) begin
            if (iMemReady || (cyc - m_start) == TMO) begin
               exp_q.push_back({m_port_d, (iMemReady && !m_we) ? m_rd : 32'd0});
               if (!iMemReady) m_to = 1;
               m_act  = 0;
               m_next = cyc + 2;
            end
         end else if (cyc >= m_next && (iIReq || iDReq)) begin
            m_port_d = iDReq && !(iIReq && m_d_run == MAX_D);
            m_d_run  = (m_port_d && iIReq) ? m_d_run + 1 : 0;
            m_we     = m_port_d ? iDWe : iIWe;
            if (m_port_d) grant_q.push_back({iDWe, iDBe, iDAddr, iDWData});
            else          grant_q.push_back({iIWe, iIBe, iIAddr, iIWData});
            m_rd    = mem_rd(m_port_d ? iDAddr : iIAddr);
            m_act   = 1;
            m_start = cyc;
         end
      end
   end

   task automatic model_reset();
      exp_q.delete();
      grant_q.delete();
      m_act = 0; m_next = 0; m_d_run = 0; m_to = 0;
   endtask

   // ---------------- memory responder ----------------
   int force_lat = 0;
   int rcnt = 0;
   int rlat = 1;

   always @(negedge iCLK) begin
      iMemReady = 1'b0;
      if (!iRST || !(oMemRe || oMemWe)) begin
         rcnt = 0;
      end else begin
         if (rcnt == 0) begin
            if (force_lat != 0) rlat = force_lat;
            else rlat = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(1, 4));
         end
         rcnt++;
         if (rcnt == rlat) begin
            iMemReady = 1'b1;
            if (oMemWe) begin
               logic [31:0] w;
               w = mem_rd(oMemAddr);
               for (int b = 0; b < 4; b++)
                  if (oMemBe[b]) w[8*b +: 8] = oMemWData[8*b +: 8];
               mem[oMemAddr] = w;
               iMemRData = $urandom;
            end else begin
               iMemRData = mem_rd(oMemAddr);
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   bit prev_en = 0;
   int en_run = 0;
   int last_len = 0;
   int n_ack_i = 0, n_ack_d = 0;
   bit ack_log[$];
   logic [68:0] g;
   logic [32:0] e;

   always @(negedge iCLK) begin
      if (!iRST) begin
         prev_en = 0;
         en_run  = 0;
      end else begin
         chk("mem_enable", oMemRe | oMemWe, m_act);
         chk("re_we_excl", oMemRe & oMemWe, 0);
         chk("dual_ack", oIAck & oDAck, 0);
         chk("timeout_flag", oTimeout, m_to);
         if ((oMemRe || oMemWe) && !prev_en) begin
            if (grant_q.size() == 0) note_fail("grant_unexpected");
            else begin
               g = grant_q.pop_front();
               chk("grant_fields", {oMemWe, oMemBe, oMemAddr, oMemWData}, g);
               chk("grant_re", oMemRe, !g[68]);
            end
         end
         if (grant_q.size() > 0) begin
            note_fail("grant_missing");
            grant_q.delete();
         end
         if (oMemRe || oMemWe) en_run++;
         else if (prev_en) begin
            last_len = en_run;
            en_run   = 0;
         end
         if (oIAck || oDAck) begin
            ack_log.push_back(oDAck);
            if (oDAck) n_ack_d++; else n_ack_i++;
            if (exp_q.size() == 0) note_fail("ack_unexpected");
            else begin
               e = exp_q.pop_front();
               chk("ack_port", oDAck, e[32]);
               chk("ack_rdata", oDAck ? oDRData : oIRData, e[31:0]);
            end
         end
         if (exp_q.size() > 0) begin
            note_fail("ack_missing");
            exp_q.delete();
         end
         prev_en = oMemRe | oMemWe;
      end
   end

   // ---------------- driver tasks ----------------
   int n_iss_i = 0, n_iss_d = 0;

   task automatic do_d(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
      int n;
      iDWe = we; iDBe = be; iDAddr = a; iDWData = wd; iDReq = 1'b1;
      n = 0;
      do begin
         @(negedge iCLK);
         n++;
      end while (!oDAck && n < 300);
      if (!oDAck) note_fail("d_ack_wait");
      iDReq = 1'b0;
      n_iss_d++;
   endtask

   task automatic do_i(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
      int n;
      iIWe = we; iIBe = be; iIAddr = a; iIWData = wd; iIReq = 1'b1;
      n = 0;
      do begin
         @(negedge iCLK);
         n++;
      end while (!oIAck && n < 300);
      if (!oIAck) note_fail("i_ack_wait");
      iIReq = 1'b0;
      n_iss_i++;
   endtask

   function automatic logic [31:0] rnd_addr(input logic [31:0] base);
      return base + {27'd0, 3'($urandom_range(0, 7)), 2'b00};
   endfunction

   // ---------------- main sequence ----------------
   int ack_i_before;
   bit pat3[6] = '{1, 1, 1, 1, 0, 1};

   initial begin
      iRST = 1'b0;
      iIReq = 0; iIWe = 0; iIBe = 0; iIAddr = 0; iIWData = 0;
      iDReq = 0; iDWe = 0; iDBe = 0; iDAddr = 0; iDWData = 0;
      iMemRData = 0; iMemReady = 0;
      repeat (3) @(negedge iCLK);
      chk("reset_outputs", {oIRData, oIAck, oDRData, oDAck, oMemRe, oMemWe, oMemBe,
                            oMemAddr, oMemWData, oTimeout}, 0);
      #2 iRST = 1'b1;
      @(negedge iCLK);

      // 1: single D read, ready after 2 cycles
      mem[32'h1001_0000] = 32'hCAFE_F00D;
      force_lat = 2;
      do_d(1'b0, 4'hF, 32'h1001_0000, 32'd0);
      chk("t1_rdata", oDRData, 32'hCAFE_F00D);
      @(negedge iCLK);
      chk("t1_re_cycles", last_len, 2);
      repeat (2) @(negedge iCLK);
      chk("t1_rdata_hold", oDRData, 32'hCAFE_F00D);

      // 2: simultaneous I read and D write, D first
      force_lat = 0;
      ack_log.delete();
      fork
         do_d(1'b1, 4'hF, 32'h1001_0004, 32'h1234_5678);
         do_i(1'b0, 4'hF, 32'h0040_0000, 32'd0);
      join
      @(negedge iCLK);
      chk("t2_ack_count", ack_log.size(), 2);
      if (ack_log.size() == 2) chk("t2_order", {ack_log[0], ack_log[1]}, 2'b10);
      chk("t2_mem_written", mem_rd(32'h1001_0004), 32'h1234_5678);

      // 3: continuous D with I pending -> 4 D, 1 I, then D
      ack_log.delete();
      fork
         begin
            for (int k = 0; k < 5; k++)
               do_d(1'b0, 4'hF, 32'h1001_0100 + 32'(k * 4), 32'd0);
         end
         do_i(1'b0, 4'hF, 32'h0040_0010, 32'd0);
      join
      @(negedge iCLK);
      chk("t3_ack_count", ack_log.size(), 6);
      for (int k = 0; k < 6; k++)
         if (k < ack_log.size()) chk("t3_order", ack_log[k], pat3[k]);

      // 4: memory never ready -> watchdog abort after TMO busy cycles
      force_lat = NEVER;
      do_d(1'b0, 4'hF, 32'h1001_0000, 32'd0);
      chk("t4_rdata_zero", oDRData, 32'd0);
      @(negedge iCLK);
      chk("t4_busy_cycles", last_len, TMO);
      repeat (5) @(negedge iCLK);
      chk("t4_timeout_sticky", oTimeout, 1'b1);

      // 5: reset while an I transaction is outstanding
      iIWe = 0; iIBe = 4'hF; iIAddr = 32'h0040_0020; iIWData = 0; iIReq = 1'b1;
      repeat (3) @(negedge iCLK);
      chk("t5_busy_before_reset", oMemRe, 1'b1);
      #2 iRST = 1'b0;
      #1;
      chk("t5_outputs_cleared", {oIRData, oIAck, oDRData, oDAck, oMemRe, oMemWe, oMemBe,
                                 oMemAddr, oMemWData, oTimeout}, 0);
      iIReq = 1'b0;
      model_reset();
      ack_i_before = n_ack_i;
      @(negedge iCLK);
      #2 iRST = 1'b1;
      repeat (4) @(negedge iCLK);
      chk("t5_no_ack", n_ack_i, ack_i_before);
      force_lat = 1;
      mem[32'h0040_0020] = 32'h0BAD_CAFE;
      do_i(1'b0, 4'hF, 32'h0040_0020, 32'd0);
      chk("t5_after_reset_rdata", oIRData, 32'h0BAD_CAFE);

      // 6: random interleaved traffic
      force_lat = 0;
      fork
         begin
            for (int k = 0; k < 50; k++) begin
               repeat ($urandom_range(0, 3)) @(negedge iCLK);
               do_i(1'($urandom_range(0, 3) == 0), 4'($urandom_range(1, 15)),
                    rnd_addr(32'h1001_0000), $urandom);
            end
         end
         begin
            for (int k = 0; k < 50; k++) begin
               repeat ($urandom_range(0, 2)) @(negedge iCLK);
               do_d(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                    rnd_addr(32'h1001_0000), $urandom);
            end
         end
      join
      repeat (4) @(negedge iCLK);
      chk("total_acks_i", n_ack_i, n_iss_i);
      chk("total_acks_d", n_ack_d, n_iss_d);

      done_flag = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      if (!done_flag) begin
         note_fail("global_time_limit");
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end
   end

endmodule
